shift_controller: RTL and testbench

SHIFT_CONTROLLER -- requirements
Module: shift_controller

---
 rtl/shift_controller_pkg.sv | 17 +
 rtl/shift_controller_core.sv | 31 +++
 rtl/shift_controller.sv | 130 +++++++++++++
 tb/tb_shift_controller.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/shift_controller_pkg.sv
// Shared definitions for the shift controller: FSM state encoding and
// the 2-bit operation code understood by shift_reg_core.
package shift_controller_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam logic [1:0] SH_HOLD = 2'd0;
   localparam logic [1:0] SH_SHR  = 2'd1;
   localparam logic [1:0] SH_SHL  = 2'd2;
   localparam logic [1:0] SH_LOAD = 2'd3;

endpackage

// File: rtl/shift_controller_core.sv
// shift_reg_core: N-bit register with hold / shift-right / shift-left / load,
// fill bit enters at the vacated end.
module shift_reg_core
   import shift_controller_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   ctrl,
   input  logic [N-1:0] din,
   input  logic         fill,
   output logic [N-1:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else begin
         case (ctrl)
            SH_SHR:  q <= {fill, q[N-1:1]};
            SH_SHL:  q <= {q[N-2:0], fill};
            SH_LOAD: q <= din;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/shift_controller.sv
// Parallel-to-serial controller: valid/ready word intake, DIV clocks per bit,
// MSB- or LSB-first. Define SHIFT_CTRL_PARITY_EN to append an even-parity bit.
module shift_controller
   import shift_controller_pkg::*;
#(
   parameter int N   = 8,
   parameter int DIV = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tx_valid,
   output logic         tx_ready,
   input  logic [N-1:0] tx_data,
   input  logic         dir,
   output logic         sout,
   output logic         sout_en,
   output logic         busy,
   output logic         done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = $clog2(N);
   localparam logic [CW-1:0] CYC_LAST = CW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

   state_e        state, state_nxt;
   logic [CW-1:0] cyc;
   logic [BW-1:0] bit_cnt;
   logic          dir_q;
   logic [1:0]    ctrl;
   logic [N-1:0]  s_q;
   logic          handshake;
   logic          bit_end;
`ifdef SHIFT_CTRL_PARITY_EN
   logic          par_q;
`endif

   assign tx_ready  = reset && (state == IDLE);
   assign handshake = tx_valid && tx_ready;
   assign bit_end   = (cyc == CYC_LAST);

   shift_reg_core #(.N(N)) u_core (
      .clk   (clk),
      .reset (reset),
      .ctrl  (ctrl),
      .din   (tx_data),
      .fill  (1'b0),
      .q     (s_q)
   );

   // NOTE: defaults first so no path through the case leaves an output
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      ctrl      = SH_HOLD;
      case (state)
         IDLE: begin
            if (handshake) begin
               state_nxt = SHIFT;
               ctrl      = SH_LOAD;
            end
         end
         SHIFT: begin
            if (bit_end) begin
               ctrl = dir_q ? SH_SHR : SH_SHL;
               if (bit_cnt == BIT_LAST) begin
`ifdef SHIFT_CTRL_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = DONE;
`endif
               end
            end
         end
`ifdef SHIFT_CTRL_PARITY_EN
         PARITY: begin
            if (bit_end) state_nxt = DONE;
         end
`endif
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cyc     <= '0;
         bit_cnt <= '0;
         dir_q   <= 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (state == SHIFT || state == PARITY) cyc <= bit_end ? '0 : cyc + CW'(1);
         else                                   cyc <= '0;
         if (state != SHIFT)                    bit_cnt <= '0;
         else if (bit_end)                      bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
         if (handshake) begin
            dir_q <= dir;
`ifdef SHIFT_CTRL_PARITY_EN
            par_q <= ^tx_data;
`endif
         end
      end
   end

   always_comb begin
      sout    = 1'b0;
      sout_en = 1'b0;
      case (state)
         SHIFT: begin
            sout    = dir_q ? s_q[0] : s_q[N-1];
            sout_en = 1'b1;
         end
`ifdef SHIFT_CTRL_PARITY_EN
         PARITY: begin
            sout    = par_q;
            sout_en = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_shift_controller.sv
// Bench for shift_controller: DIV=2 and DIV=1 instances, table of frames with
// a per-cycle scoreboard, plus reset-abort and back-to-back sequences.
module tb_shift_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       dir = 1'b0;
   logic       sel = 1'b0;

   logic tx_ready_a, sout_a, sout_en_a, busy_a, done_a;
   logic tx_ready_b, sout_b, sout_en_b, busy_b, done_b;

`ifdef SHIFT_CTRL_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   shift_controller #(.N(8), .DIV(2)) dut_a (
      .clk(clk), .reset(reset), .tx_valid(tx_valid && !sel), .tx_ready(tx_ready_a),
      .tx_data(tx_data), .dir(dir), .sout(sout_a), .sout_en(sout_en_a),
      .busy(busy_a), .done(done_a)
   );

   shift_controller #(.N(8), .DIV(1)) dut_b (
      .clk(clk), .reset(reset), .tx_valid(tx_valid && sel), .tx_ready(tx_ready_b),
      .tx_data(tx_data), .dir(dir), .sout(sout_b), .sout_en(sout_en_b),
      .busy(busy_b), .done(done_b)
   );

   wire m_ready = sel ? tx_ready_b : tx_ready_a;
   wire m_sout  = sel ? sout_b     : sout_a;
   wire m_en    = sel ? sout_en_b  : sout_en_a;
   wire m_busy  = sel ? busy_b     : busy_a;
   wire m_done  = sel ? done_b     : done_a;

   // sequence: emission order, bit 7 leaves first
   typedef struct {
      logic       sel;
      logic       d;
      logic [7:0] w;
      logic [7:0] seq;
      logic       par;
      logic       hold;
   } vec_t;

   typedef struct packed {
      logic sout;
      logic en;
      logic busy;
      logic done;
      logic ready;
   } exp_t;

   vec_t vecs[7];
   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Starts at a negedge with the selected DUT idle; returns at the negedge
   // of the first idle cycle after done.
   task automatic run_frame(input vec_t v);
      int   div = v.sel ? 1 : 2;
      int   len = 8 * div + (PAR_EN ? div : 0);
      exp_t e;
      sel      = v.sel;
      tx_valid = 1'b1;
      tx_data  = v.w;
      dir      = v.d;
      check($sformatf("ready_before_%02h", v.w), m_ready, 1);
      for (int c = 1; c <= len + 2; c++) begin
         if (c <= len) begin
            int idx = (c - 1) / div;
            e = '{sout: (idx < 8) ? v.seq[7 - idx] : v.par, en: 1'b1,
                  busy: 1'b1, done: 1'b0, ready: 1'b0};
         end else if (c == len + 1) begin
            e = '{sout: 1'b0, en: 1'b0, busy: 1'b1, done: 1'b1, ready: 1'b0};
         end else begin
            e = '{sout: 1'b0, en: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1};
         end
         exp_q.push_back(e);
      end
      for (int c = 1; c <= len + 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("frame_%02h_cyc%0d", v.w, c),
               {m_sout, m_en, m_busy, m_done, m_ready}, e);
         if (!v.hold && c == 1) tx_valid = 1'b0;
         if (c <= len + 1) begin
            tx_data = 8'($urandom);
            dir     = ~dir;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound reached");
      $fatal(1, "timeout");
   end

   initial begin
      int   dones;
      vec_t v;
      vecs[0] = '{sel: 1'b0, d: 1'b0, w: 8'hA5, seq: 8'b10100101, par: 1'b0, hold: 1'b0};
      vecs[1] = '{sel: 1'b1, d: 1'b1, w: 8'h01, seq: 8'b10000000, par: 1'b1, hold: 1'b0};
      vecs[2] = '{sel: 1'b1, d: 1'b0, w: 8'h80, seq: 8'b10000000, par: 1'b1, hold: 1'b0};
      vecs[3] = '{sel: 1'b0, d: 1'b0, w: 8'h3C, seq: 8'b00111100, par: 1'b0, hold: 1'b1};
      vecs[4] = '{sel: 1'b0, d: 1'b1, w: 8'hC3, seq: 8'b11000011, par: 1'b0, hold: 1'b0};
      vecs[5] = '{sel: 1'b0, d: 1'b0, w: 8'h07, seq: 8'b00000111, par: 1'b1, hold: 1'b0};
      vecs[6] = '{sel: 1'b0, d: 1'b1, w: 8'h03, seq: 8'b11000000, par: 1'b0, hold: 1'b0};

      #1;
      check("rst_ready", m_ready, 0);
      check("rst_outs", {m_sout, m_en, m_busy, m_done}, 4'b0000);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("ready_after_release", m_ready, 1);
      @(negedge clk);

      foreach (vecs[i]) run_frame(vecs[i]);

      // reset during bit 3 of 8'hFF
      sel      = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      dir      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_bit3_sout", {m_sout, m_en, m_busy}, 3'b111);
      #2 reset = 1'b0;
      #1;
      check("abort_outs", {m_sout, m_en, m_busy, m_done, m_ready}, 5'b00000);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_ready", {m_ready, m_busy}, 2'b10);
      dones = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (m_done || m_busy) dones++;
      end
      check("abort_no_done", dones, 0);
      v = '{sel: 1'b0, d: 1'b1, w: 8'h96, seq: 8'b01101001, par: 1'b0, hold: 1'b0};
      run_frame(v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
